cci_mpf_shim_rd_rsp_tag: RTL
============================

CCI_MPF_SHIM_RD_RSP_TAG -- requirements
Module: cci_mpf_shim_rd_rsp_tag

Interface
REQ-001 Parameter N_TAGS, default 64, number of outstanding read tags; power of 2, 8..512.
REQ-002 Parameter ALMOST_FULL_SLACK, default CCI_ALMOST_FULL_THRESHOLD, free-tag count at or below which the AFU is throttled.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 afu_c0Tx  input  t_if_cci_mpf_c0_Tx  AFU read requests with MPF header.
REQ-006 afu_c0TxAlmFull  output  1  throttle to AFU.
REQ-007 fiu_c0Tx  output  t_if_cci_mpf_c0_Tx  tagged read requests toward FIU.
REQ-008 fiu_c0TxAlmFull  input  1  FIU-side throttle.
REQ-009 fiu_c0Rx  input  t_if_cci_c0_Rx  responses from FIU.
REQ-010 afu_c0Rx  output  t_if_cci_c0_Rx  responses to AFU with original mdata restored.
REQ-011 err_badTag  output  1  sticky flag: response carried an unallocated tag.

Function
REQ-012 States INIT and RUN; reset enters INIT; INIT walks a counter 0..N_TAGS-1, pushing one tag per cycle into the free-tag FIFO; RUN entered the cycle after tag N_TAGS-1 is pushed.
REQ-013 In INIT afu_c0TxAlmFull = 1 and no request is accepted.
REQ-014 In RUN afu_c0TxAlmFull = fiu_c0TxAlmFull OR (free count <= ALMOST_FULL_SLACK), registered.
REQ-015 afu_c0Tx.rdValid = 1 pops one tag, writes full original mdata to table[tag], and drives fiu_c0Tx one cycle later with hdr identical except base.mdata[log2(N_TAGS)-1:0] = tag.
REQ-016 fiu_c0Tx.rdValid = 0 in every cycle without an accepted request; all other header fields pass unchanged, including ext fields.
REQ-017 fiu_c0Rx.rdValid = 1: index = hdr.mdata[log2(N_TAGS)-1:0]; afu_c0Rx driven one cycle later with data, resp_type unchanged and mdata = table[index]; tag pushed to free FIFO the same cycle.
REQ-018 fiu_c0Rx entries without rdValid (e.g. wrValid, umsg) pass to afu_c0Rx with one-cycle delay, unmodified.
REQ-019 Response latency fixed at 1 cycle; request latency fixed at 1 cycle; no backpressure on the Rx path.
REQ-020 Simultaneous pop and push in one cycle: both take effect; free count unchanged; a tag freed in cycle N is allocatable no earlier than N+1.
REQ-021 Request with free FIFO empty is a protocol violation: simulation assertion fires; request is dropped, no tag popped.
REQ-022 Free count width log2(N_TAGS)+1; never exceeds N_TAGS.

Reset
REQ-023 Reset held: fiu_c0Tx.rdValid = 0, afu_c0Rx valids = 0, afu_c0TxAlmFull = 1, err_badTag = 0, free count = 0, state INIT.
REQ-024 Reset mid-operation discards all outstanding tags; responses arriving during or after reset for pre-reset tags are undefined, not required to be forwarded.

Configuration
REQ-025 Macro CCI_MPF_SHIM_RD_RSP_TAG_ERR_CHECK_EN defined: N_TAGS-bit busy vector set on allocate, cleared on response; response to non-busy tag sets err_badTag (sticky until reset) and the response is still forwarded.
REQ-026 Macro undefined: no busy vector; err_badTag tied 0.

Structure
REQ-027 N_TAGS default and tag typedef t_cci_mpf_rd_tag belong in the shared cci_mpf_if_pkg; header field access uses that package's helper functions.
REQ-028 One sub-module: cci_mpf_prim_fifo_lutram, holding the free-tag list; mdata table is a simple dual-port memory inside the block.

Verification
REQ-029 Reset released -> afu_c0TxAlmFull = 1 for 64 cycles, then 0; free count = 64.
REQ-030 Read with mdata 0xABCD -> fiu_c0Tx one cycle later, mdata low 6 bits = allocated tag; response with that tag -> afu_c0Rx mdata 0xABCD one cycle later.
REQ-031 Issue 64 reads without responses -> almFull asserts when free count reaches ALMOST_FULL_SLACK; all 64 tags distinct.
REQ-032 Responses returned in reverse order of 16 requests -> each afu_c0Rx mdata matches its own request.
REQ-033 Request and response in the same cycle with 1 free tag -> no assertion, free count stays 1.
REQ-034 With ERR_CHECK_EN, inject response tag 5 never allocated -> err_badTag = 1 next cycle, held until reset.

Source files
------------

// File: rtl/cci_mpf_if_pkg.sv
// Shared MPF/CCI types, constants and header access helpers.
// Used by the read response tag shim and its free-tag FIFO.
package cci_mpf_if_pkg;

    localparam int CCI_MPF_N_RD_TAGS = 64;
    localparam int CCI_ALMOST_FULL_THRESHOLD = 8;
    localparam int CCI_MDATA_WIDTH = 16;
    localparam int CCI_CLADDR_WIDTH = 42;
    localparam int CCI_CLDATA_WIDTH = 512;

    typedef logic [$clog2(CCI_MPF_N_RD_TAGS)-1:0] t_cci_mpf_rd_tag;
    typedef logic [CCI_MDATA_WIDTH-1:0] t_cci_mdata;

    typedef struct packed {
        logic [1:0]                  vc_sel;
        logic [1:0]                  cl_len;
        logic [3:0]                  req_type;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        t_cci_mdata                  mdata;
    } t_cci_c0_ReqMemHdr;

    typedef struct packed {
        logic addrIsVirtual;
        logic mapVAtoPhysChannel;
        logic checkLoadStoreOrder;
    } t_cci_mpf_ReqMemHdrExt;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_c0_ReqMemHdr     base;
    } t_cci_mpf_c0_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_c0_ReqMemHdr hdr;
        logic                  rdValid;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        logic [1:0] vc_used;
        logic       hit_miss;
        logic [1:0] cl_num;
        logic [3:0] resp_type;
        t_cci_mdata mdata;
    } t_cci_c0_RspMemHdr;

    typedef struct packed {
        t_cci_c0_RspMemHdr           hdr;
        logic [CCI_CLDATA_WIDTH-1:0] data;
        logic                        rdValid;
        logic                        wrValid;
        logic                        umsgValid;
    } t_if_cci_c0_Rx;

    function automatic t_cci_mdata cci_mpf_c0_get_mdata(t_if_cci_mpf_c0_Tx tx);
        return tx.hdr.base.mdata;
    endfunction

    function automatic t_if_cci_mpf_c0_Tx cci_mpf_c0_set_mdata(
        t_if_cci_mpf_c0_Tx tx, t_cci_mdata md);
        t_if_cci_mpf_c0_Tx r;
        r = tx;
        r.hdr.base.mdata = md;
        return r;
    endfunction

    function automatic t_cci_mdata cci_c0_rx_get_mdata(t_if_cci_c0_Rx rx);
        return rx.hdr.mdata;
    endfunction

    function automatic t_if_cci_c0_Rx cci_c0_rx_set_mdata(
        t_if_cci_c0_Rx rx, t_cci_mdata md);
        t_if_cci_c0_Rx r;
        r = rx;
        r.hdr.mdata = md;
        return r;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small FIFO with asynchronous head read, used as the free-tag list.
// An entry written in cycle N is visible at the head from cycle N+1.
module cci_mpf_prim_fifo_lutram
    import cci_mpf_if_pkg::*;
#(
    parameter int N_ENTRIES = CCI_MPF_N_RD_TAGS,
    parameter int WIDTH = $clog2(CCI_MPF_N_RD_TAGS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_en,
    input  logic             deq_en,
    output logic [WIDTH-1:0] first,
    output logic             not_empty
);

    localparam int PTR_W = $clog2(N_ENTRIES);

    logic [WIDTH-1:0] mem [N_ENTRIES];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_deq;

    always_comb begin
        do_deq = deq_en && (cnt_q != '0);
        wr_ptr_d = enq_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d = cnt_q + (PTR_W+1)'(enq_en) - (PTR_W+1)'(do_deq);
        first = mem[rd_ptr_q];
        not_empty = (cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (enq_en) begin
            mem[wr_ptr_q] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cci_mpf_shim_rd_rsp_tag.sv
// Read tag shim: swaps AFU mdata for a private tag and restores it on the response.
// CCI_MPF_SHIM_RD_RSP_TAG_ERR_CHECK_EN adds a busy vector and sticky err_badTag.
module cci_mpf_shim_rd_rsp_tag
    import cci_mpf_if_pkg::*;
#(
    parameter int N_TAGS = CCI_MPF_N_RD_TAGS,
    parameter int ALMOST_FULL_SLACK = CCI_ALMOST_FULL_THRESHOLD
)(
    input  logic              clk,
    input  logic              reset,
    input  t_if_cci_mpf_c0_Tx afu_c0Tx,
    output logic              afu_c0TxAlmFull,
    output t_if_cci_mpf_c0_Tx fiu_c0Tx,
    input  logic              fiu_c0TxAlmFull,
    input  t_if_cci_c0_Rx     fiu_c0Rx,
    output t_if_cci_c0_Rx     afu_c0Rx,
    output logic              err_badTag
);

    localparam int TAG_W = $clog2(N_TAGS);

    typedef logic [TAG_W-1:0] t_tag;
    typedef logic [TAG_W:0]   t_cnt;
    typedef enum logic { ST_INIT, ST_RUN } t_state;

    t_state            state_q, state_d;
    t_tag              init_cnt_q, init_cnt_d;
    t_cnt              free_cnt_q, free_cnt_d;
    logic              alm_full_q, alm_full_d;
    t_if_cci_mpf_c0_Tx fiu_tx_q, fiu_tx_d;
    t_if_cci_c0_Rx     afu_rx_q, afu_rx_d;
    t_cci_mdata        mdata_tbl [N_TAGS];

    logic req_acc, rsp_rd, rsp_ok, fifo_enq, fifo_not_empty;
    t_tag rsp_idx, fifo_first, fifo_enq_data;
    t_cci_mdata req_md;

    cci_mpf_prim_fifo_lutram #(
        .N_ENTRIES(N_TAGS),
        .WIDTH(TAG_W)
    ) free_tags (
        .clk(clk),
        .reset(reset),
        .enq_data(fifo_enq_data),
        .enq_en(fifo_enq),
        .deq_en(req_acc),
        .first(fifo_first),
        .not_empty(fifo_not_empty)
    );

`ifdef CCI_MPF_SHIM_RD_RSP_TAG_ERR_CHECK_EN
    logic [N_TAGS-1:0] busy_q, busy_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        req_acc = (state_q == ST_RUN) && afu_c0Tx.rdValid && fifo_not_empty;
        rsp_idx = t_tag'(cci_c0_rx_get_mdata(fiu_c0Rx));
        rsp_rd = (state_q == ST_RUN) && fiu_c0Rx.rdValid;
`ifdef CCI_MPF_SHIM_RD_RSP_TAG_ERR_CHECK_EN
        rsp_ok = busy_q[rsp_idx];
        busy_d = busy_q;
        if (req_acc) busy_d[fifo_first] = 1'b1;
        if (rsp_rd && rsp_ok) busy_d[rsp_idx] = 1'b0;
        err_d = err_q || (rsp_rd && !rsp_ok);
`else
        // Without tracking, refuse a return that would overflow the free list
        rsp_ok = (free_cnt_q != t_cnt'(N_TAGS)) || req_acc;
`endif
        fifo_enq = (state_q == ST_INIT) || (rsp_rd && rsp_ok);
        fifo_enq_data = (state_q == ST_INIT) ? init_cnt_q : rsp_idx;
        free_cnt_d = free_cnt_q + t_cnt'(fifo_enq) - t_cnt'(req_acc);

        init_cnt_d = (state_q == ST_INIT) ? init_cnt_q + 1'b1 : init_cnt_q;
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt_q == t_tag'(N_TAGS - 1)) begin
            state_d = ST_RUN;
        end
        alm_full_d = (state_d == ST_INIT) || fiu_c0TxAlmFull ||
                     (free_cnt_d <= t_cnt'(ALMOST_FULL_SLACK));

        req_md = cci_mpf_c0_get_mdata(afu_c0Tx);
        if (req_acc) req_md[TAG_W-1:0] = fifo_first;
        fiu_tx_d = cci_mpf_c0_set_mdata(afu_c0Tx, req_md);
        fiu_tx_d.rdValid = req_acc;

        afu_rx_d = fiu_c0Rx;
        if (fiu_c0Rx.rdValid) begin
            afu_rx_d = cci_c0_rx_set_mdata(fiu_c0Rx, mdata_tbl[rsp_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (req_acc) begin
            mdata_tbl[fifo_first] <= cci_mpf_c0_get_mdata(afu_c0Tx);
        end
    end

    always_ff @(posedge clk) begin
        fiu_tx_q <= fiu_tx_d;
        afu_rx_q <= afu_rx_d;
        if (reset) begin
            state_q <= ST_INIT;
            init_cnt_q <= '0;
            free_cnt_q <= '0;
            alm_full_q <= 1'b1;
            fiu_tx_q.rdValid <= 1'b0;
            afu_rx_q.rdValid <= 1'b0;
            afu_rx_q.wrValid <= 1'b0;
            afu_rx_q.umsgValid <= 1'b0;
        end else begin
            state_q <= state_d;
            init_cnt_q <= init_cnt_d;
            free_cnt_q <= free_cnt_d;
            alm_full_q <= alm_full_d;
        end
    end

`ifdef CCI_MPF_SHIM_RD_RSP_TAG_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q <= err_d;
        end
    end

    assign err_badTag = err_q;
`else
    assign err_badTag = 1'b0;
`endif

    // A request with no free tag is an AFU protocol violation
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_RUN && afu_c0Tx.rdValid) begin
            assert (fifo_not_empty)
            else $error("rd_rsp_tag: request with no free tag");
        end
    end

    assign fiu_c0Tx = fiu_tx_q;
    assign afu_c0Rx = afu_rx_q;
    assign afu_c0TxAlmFull = alm_full_q;

endmodule
